// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline: stage limit, per-stage debug
// control view and the popcount used for the occupancy output.
package pipe_pkg;

    localparam int PIPE_MAX_STAGES = 16;
    localparam int PIPE_CNT_W      = $clog2(PIPE_MAX_STAGES + 1);

    typedef struct packed {
        logic valid;    // registered valid bit of the stage
        logic flushed;  // stage holds an entry that is being killed this cycle
    } pipe_ctrl_t;

    function automatic logic [PIPE_CNT_W-1:0] popcount(input logic [PIPE_MAX_STAGES-1:0] bits);
        logic [PIPE_CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < PIPE_MAX_STAGES; i++) begin
            cnt = cnt + PIPE_CNT_W'(bits[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/elastic_pipe_stage.sv
// One register slice of the elastic pipe: a valid bit plus a clock-enabled
// payload register. Load wins over clear; otherwise the slice holds.
module elastic_pipe_stage #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // NOTE: sequential state uses non-blocking assignments so every stage samples
    // its predecessor's pre-edge value, which is what makes the chain shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    // NOTE: the payload register is reset too, so invalid stages never read X
    // and downstream logic sees a known RESET_DATA value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= RESET_DATA;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/elastic_pipe.sv
// N-stage valid/ready pipeline with bubble collapsing and per-stage flush.
// The ready chain and flush masking live here; storage lives in the slices.
module elastic_pipe
    import pipe_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter int               STAGES     = 4,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    input  logic [STAGES-1:0]             flush_mask,
    output logic [STAGES-1:0]             stage_valid,
    output logic [$clog2(STAGES+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(STAGES + 1);

    logic [STAGES-1:0]          w_valid;
    logic [STAGES-1:0]          w_live;
    logic [STAGES-1:0]          w_rdy;
    logic [STAGES-1:0]          w_next_rdy;
    logic [STAGES-1:0]          w_load;
    logic [STAGES-1:0]          w_clear;
    logic [PIPE_MAX_STAGES-1:0] w_valid_ext;
    pipe_ctrl_t                 w_ctrl [STAGES];
    logic [WIDTH-1:0]           w_din  [STAGES];
    logic [WIDTH-1:0]           w_dout [STAGES];

    // NOTE: every output of a combinational block gets a default first so no
    // path through the block can infer a latch.
    always_comb begin : ctrl_chain
        logic w_carry;
        w_live     = '0;
        w_rdy      = '0;
        w_next_rdy = '0;
        w_load     = '0;
        w_clear    = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_ctrl[i].valid   = w_valid[i];
            w_ctrl[i].flushed = w_valid[i] & flush_mask[i];
            w_live[i]         = w_ctrl[i].valid & ~w_ctrl[i].flushed;
        end
        // Ready ripples from the output back to stage 0; a dead stage is always ready.
        w_carry = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_next_rdy[i] = w_carry;
            w_rdy[i]      = ~w_live[i] | w_carry;
            w_carry       = w_rdy[i];
        end
        w_carry = in_valid;
        for (int i = 0; i < STAGES; i++) begin
            w_load[i]  = w_carry & w_rdy[i];
            w_clear[i] = (w_live[i] & w_next_rdy[i]) | w_ctrl[i].flushed;
            w_carry    = w_live[i];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign w_din[g] = in_data;
        end else begin : g_link
            assign w_din[g] = w_dout[g-1];
        end

        elastic_pipe_stage #(
            .WIDTH      (WIDTH),
            .RESET_DATA (RESET_DATA)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_load  (w_load[g]),
            .i_clear (w_clear[g]),
            .i_data  (w_din[g]),
            .o_valid (w_valid[g]),
            .o_data  (w_dout[g])
        );
    end

    always_comb begin
        w_valid_ext               = '0;
        w_valid_ext[STAGES-1:0]   = w_valid;
    end

    assign in_ready    = w_rdy[0];
    assign out_valid   = w_live[STAGES-1];
    assign out_data    = w_dout[STAGES-1];
    assign stage_valid = w_valid;
    assign occupancy   = OCC_W'(popcount(w_valid_ext));

endmodule

// File: tb/tb_elastic_pipe.sv
// Self-checking bench for elastic_pipe: directed scenarios plus randomized
// traffic compared against a queue-of-entries reference model.
module tb_elastic_pipe;

    localparam int          WIDTH   = 32;
    localparam int          STAGES  = 4;
    localparam logic [31:0] RST_VAL = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [3:0]  flush_mask = '0;
    logic [3:0]  stage_valid;
    logic [2:0]  occupancy;

    elastic_pipe #(
        .WIDTH      (WIDTH),
        .STAGES     (STAGES),
        .RESET_DATA (RST_VAL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .flush_mask  (flush_mask),
        .stage_valid (stage_valid),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: entries ordered oldest first, each with its stage position.
    typedef struct {
        int          pos;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    ent_t        nq[$];
    logic [31:0] dut_log[$];
    bit          exp_in_ready;
    bit          exp_out_valid;
    logic [31:0] exp_out_data;
    logic [3:0]  exp_sv;
    int          exp_occ;
    int          cyc;
    int          first_acc;
    int          first_ov;
    bit          ir_low;

    // An entry advances unless the entry directly ahead of it stays put; the
    // oldest entry at the last position leaves when the consumer is ready.
    function automatic void model_eval(input logic [3:0] fm, input logic ordy);
        ent_t e;
        bit   stays;
        bit   ahead_stays;
        int   ahead_pos;
        int   old_pos;
        bit   blocked0;
        exp_sv        = '0;
        exp_occ       = mq.size();
        exp_out_valid = 1'b0;
        exp_out_data  = '0;
        ahead_stays   = 1'b0;
        ahead_pos     = -10;
        blocked0      = 1'b0;
        nq.delete();
        foreach (mq[k]) begin
            exp_sv[mq[k].pos] = 1'b1;
            if (fm[mq[k].pos]) continue;
            e       = mq[k];
            old_pos = e.pos;
            if (e.pos == STAGES - 1) begin
                exp_out_valid = 1'b1;
                exp_out_data  = e.data;
                stays         = !ordy;
            end else begin
                stays = ahead_stays && (ahead_pos == e.pos + 1);
            end
            if (stays) begin
                nq.push_back(e);
                if (e.pos == 0) blocked0 = 1'b1;
            end else if (e.pos < STAGES - 1) begin
                e.pos = e.pos + 1;
                nq.push_back(e);
            end
            ahead_stays = stays;
            ahead_pos   = old_pos;
        end
        exp_in_ready = !blocked0;
    endfunction

    function automatic void model_update(input logic iv, input logic [31:0] id);
        ent_t e;
        mq = nq;
        if (iv && exp_in_ready) begin
            e.pos  = 0;
            e.data = id;
            mq.push_back(e);
        end
    endfunction

    task automatic step(input logic iv, input logic [31:0] id, input logic ordy, input logic [3:0] fm);
        in_valid   = iv;
        in_data    = id;
        out_ready  = ordy;
        flush_mask = fm;
        #1;
        model_eval(fm, ordy);
        check("in_ready", 32'(in_ready), 32'(exp_in_ready));
        check("out_valid", 32'(out_valid), 32'(exp_out_valid));
        if (exp_out_valid) check("out_data", out_data, exp_out_data);
        check("stage_valid", 32'(stage_valid), 32'(exp_sv));
        check("occupancy", 32'(occupancy), 32'(exp_occ));
        if (out_valid && out_ready) dut_log.push_back(out_data);
        if (in_valid && in_ready && first_acc < 0) first_acc = cyc;
        if (out_valid && first_ov < 0) first_ov = cyc;
        if (!in_ready) ir_low = 1'b1;
        @(posedge clk);
        model_update(iv, id);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        flush_mask = '0;
        #1;
        check("rst_stage_valid", 32'(stage_valid), 32'h0);
        check("rst_occupancy", 32'(occupancy), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_out_data", out_data, RST_VAL);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mq.delete();
        dut_log.delete();
        cyc       = 0;
        first_acc = -1;
        first_ov  = -1;
        ir_low    = 1'b0;
    endtask

    initial begin
        #2;

        // Streaming: latency STAGES, one word per cycle, occupancy settles at 4.
        do_reset();
        for (int k = 1; k <= 12; k++) step(1'b1, 32'(k), 1'b1, 4'h0);
        check("t1_latency", 32'(first_ov - first_acc), 32'd4);
        check("t1_occ", 32'(occupancy), 32'd4);
        check("t1_count", 32'(dut_log.size()), 32'd8);
        foreach (dut_log[i]) check("t1_order", dut_log[i], 32'(i + 1));

        // Backpressure: full pipe holds bit-exact, then drains in order.
        do_reset();
        for (int k = 1; k <= 4; k++) step(1'b1, 32'(k), 1'b0, 4'h0);
        for (int k = 0; k < 5; k++) step(1'b1, 32'h99, 1'b0, 4'h0);
        check("t2_in_ready", 32'(in_ready), 32'h0);
        check("t2_full", 32'(stage_valid), 32'hF);
        check("t2_hold", out_data, 32'h1);
        for (int k = 0; k < 8; k++) step(1'b0, 32'h0, 1'b1, 4'h0);
        check("t2_count", 32'(dut_log.size()), 32'd4);
        foreach (dut_log[i]) check("t2_order", dut_log[i], 32'(i + 1));

        // Bubble collapse: idle gaps vanish while the output is stalled.
        do_reset();
        step(1'b1, 32'h1, 1'b0, 4'h0);
        step(1'b0, 32'h0, 1'b0, 4'h0);
        step(1'b0, 32'h0, 1'b0, 4'h0);
        for (int k = 2; k <= 4; k++) step(1'b1, 32'(k), 1'b0, 4'h0);
        check("t3_in_ready_held", 32'(ir_low), 32'h0);
        check("t3_full", 32'(stage_valid), 32'hF);
        step(1'b1, 32'h5, 1'b0, 4'h0);
        for (int k = 0; k < 8; k++) step(1'b0, 32'h0, 1'b1, 4'h0);
        check("t3_count", 32'(dut_log.size()), 32'd4);
        foreach (dut_log[i]) check("t3_order", dut_log[i], 32'(i + 1));

        // Branch flush of the two youngest entries with a simultaneous input.
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b1, 32'hA + 32'(k), 1'b0, 4'h0);
        step(1'b1, 32'hE, 1'b0, 4'b0011);
        for (int k = 0; k < 8; k++) step(1'b0, 32'h0, 1'b1, 4'h0);
        check("t4_count", 32'(dut_log.size()), 32'd3);
        if (dut_log.size() == 3) begin
            check("t4_first", dut_log[0], 32'hA);
            check("t4_second", dut_log[1], 32'hB);
            check("t4_third", dut_log[2], 32'hE);
        end

        // Flush of the last stage suppresses delivery in the same cycle.
        do_reset();
        step(1'b1, 32'h5, 1'b0, 4'h0);
        for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 1'b0, 4'h0);
        check("t5_at_tail", 32'(stage_valid), 32'h8);
        step(1'b0, 32'h0, 1'b1, 4'b1000);
        for (int k = 0; k < 4; k++) step(1'b0, 32'h0, 1'b1, 4'h0);
        check("t5_dropped", 32'(dut_log.size()), 32'd0);
        check("t5_empty", 32'(stage_valid), 32'h0);

        // Asynchronous reset between edges while full.
        do_reset();
        for (int k = 1; k <= 4; k++) step(1'b1, 32'(k), 1'b0, 4'h0);
        in_valid  = 1'b1;
        in_data   = 32'h77;
        out_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("t6_stage_valid", 32'(stage_valid), 32'h0);
        check("t6_occupancy", 32'(occupancy), 32'h0);
        check("t6_out_valid", 32'(out_valid), 32'h0);
        check("t6_in_ready", 32'(in_ready), 32'h1);
        check("t6_out_data", out_data, RST_VAL);
        mq.delete();
        @(posedge clk);
        #1;
        check("t6_no_transfer", 32'(stage_valid), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        dut_log.delete();
        for (int k = 0; k < 6; k++) step(1'b1, 32'h11 + 32'(k), 1'b1, 4'h0);

        // Randomized traffic in phases of differing pressure and flush rate.
        do_reset();
        for (int ph = 0; ph < 8; ph++) begin
            for (int k = 0; k < 100; k++) begin
                logic       iv;
                logic       ordy;
                logic [3:0] fm;
                iv   = ($urandom_range(0, 7) < 7 - ph % 4);
                ordy = ($urandom_range(0, 7) < 2 + ph % 5);
                fm   = ($urandom_range(0, 9) < ph % 3) ? 4'($urandom) : 4'h0;
                step(iv, $urandom, ordy, fm);
            end
        end
        for (int k = 0; k < 10; k++) step(1'b0, 32'h0, 1'b1, 4'h0);
        check("rand_drained", 32'(stage_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
